// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/stop, lap and clear buttons,
// 4-digit BCD 10 ms counter with lap snapshot and sticky overflow.
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 500_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [15:0] digits,
    output logic        running,
    output logic        lap_hold,
    output logic        tick,
    output logic        ovf
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

    state_t        state;
    state_t        nxt;
    logic [2:0]    raw;
    logic [2:0]    s1;
    logic [2:0]    s2;
    logic [2:0]    level;
    logic [2:0]    level_q;
    logic [2:0]    press;
    logic [DW-1:0] db_cnt [3];
    logic [PW-1:0] presc;
    logic [15:0]   live;
    logic [15:0]   snap;
    logic          run_st;
    logic          p_clr;
    logic          p_ss;
    logic          p_lap;

    // bit 0 lap, bit 1 start/stop, bit 2 clear
    assign raw = {btn_clear, btn_start_stop, btn_lap};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            level   <= '0;
            level_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            level_q <= level;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level[i]  <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign press = level & ~level_q;
    assign p_clr = press[2];
    assign p_ss  = press[1] & ~press[2];
    assign p_lap = press[0] & ~press[1] & ~press[2];

    assign run_st = (state == RUN) || (state == LAP);
    assign tick   = run_st && (presc == PW'(TICK_DIV - 1));

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] >= 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (p_ss) nxt = RUN;
            RUN: begin
                if (p_ss)       nxt = STOP;
                else if (p_lap) nxt = LAP;
            end
            LAP: begin
                if (p_ss)       nxt = STOP;
                else if (p_lap) nxt = RUN;
            end
            STOP: begin
                if (p_clr)     nxt = IDLE;
                else if (p_ss) nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            live     <= '0;
            snap     <= '0;
            digits   <= '0;
            ovf      <= 1'b0;
            running  <= 1'b0;
            lap_hold <= 1'b0;
        end else begin
            state    <= nxt;
            running  <= (nxt == RUN) || (nxt == LAP);
            lap_hold <= (nxt == LAP);
            digits   <= (state == LAP) ? snap : live;

            if (state == IDLE)  presc <= '0;
            else if (tick)      presc <= '0;
            else if (run_st)    presc <= presc + PW'(1);

            if (tick) begin
                live <= bcd_inc(live);
                if (live == 16'h9999) ovf <= 1'b1;
            end

            if (state == RUN && nxt == LAP) snap <= live;

            // clear from STOP wipes everything, overriding the hold above
            if (state == STOP && nxt == IDLE) begin
                live  <= '0;
                snap  <= '0;
                presc <= '0;
                ovf   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized and directed bench for stopwatch_ctrl against an
// integer-arithmetic reference model.
module tb_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int DB = 3;

    logic        clk;
    logic        rst;
    logic        btn_start_stop;
    logic        btn_lap;
    logic        btn_clear;
    logic [15:0] digits;
    logic        running;
    logic        lap_hold;
    logic        tick;
    logic        ovf;

    stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .digits         (digits),
        .running        (running),
        .lap_hold       (lap_hold),
        .tick           (tick),
        .ovf            (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_RUN, M_LAP, M_STOP} mode_t;

    int         checks;
    int         failures;
    mode_t      m_mode;
    int         m_count;
    int         m_frac;
    int         m_snap;
    int         m_disp;
    bit         m_ovf;
    logic [2:0] hist[$];
    logic [2:0] m_prev;
    logic [2:0] m_acc;
    logic [2:0] m_pend;
    int         m_run[3];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    function automatic bit live_mode(input mode_t m);
        return (m == M_RUN) || (m == M_LAP);
    endfunction

    task automatic mreset();
        m_mode  = M_IDLE;
        m_count = 0;
        m_frac  = 0;
        m_snap  = 0;
        m_disp  = 0;
        m_ovf   = 1'b0;
        m_prev  = '0;
        m_acc   = '0;
        m_pend  = '0;
        hist    = {};
        hist.push_back(3'b000);
        hist.push_back(3'b000);
        for (int i = 0; i < 3; i++) m_run[i] = 0;
    endtask

    task automatic step();
        logic [2:0] raw;
        logic [2:0] samp;
        int         old_count;
        bit         tk;
        bit         pc;
        bit         ps;
        bit         pl;
        if (rst) begin
            mreset();
            return;
        end
        pc = m_pend[2];
        ps = m_pend[1] && !pc;
        pl = m_pend[0] && !pc && !m_pend[1];
        tk = live_mode(m_mode) && (m_frac == TD - 1);
        m_disp = (m_mode == M_LAP) ? m_snap : m_count;
        old_count = m_count;
        if (tk) begin
            if (m_count == 9999) m_ovf = 1'b1;
            m_count = (m_count + 1) % 10000;
        end
        if (m_mode == M_IDLE)        m_frac = 0;
        else if (live_mode(m_mode))  m_frac = (m_frac + 1) % TD;
        case (m_mode)
            M_IDLE: if (ps) m_mode = M_RUN;
            M_RUN: begin
                if (ps) m_mode = M_STOP;
                else if (pl) begin
                    m_mode = M_LAP;
                    m_snap = old_count;
                end
            end
            M_LAP: begin
                if (ps)      m_mode = M_STOP;
                else if (pl) m_mode = M_RUN;
            end
            M_STOP: begin
                if (pc) begin
                    m_mode  = M_IDLE;
                    m_count = 0;
                    m_snap  = 0;
                    m_frac  = 0;
                    m_ovf   = 1'b0;
                end else if (ps) begin
                    m_mode = M_RUN;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        // sample seen by the debouncer is the raw level two edges old
        raw = {btn_clear, btn_start_stop, btn_lap};
        hist.push_back(raw);
        samp = hist.pop_front();
        m_pend = '0;
        for (int i = 0; i < 3; i++) begin
            if (samp[i] == m_prev[i]) m_run[i]++;
            else m_run[i] = 1;
            m_prev[i] = samp[i];
            if (m_run[i] >= DB && samp[i] != m_acc[i]) begin
                m_acc[i] = samp[i];
                if (samp[i]) m_pend[i] = 1'b1;
            end
        end
    endtask

    task automatic compare();
        check("digits", 32'(digits), 32'(to_bcd(m_disp)));
        check("running", 32'(running), 32'(live_mode(m_mode)));
        check("lap_hold", 32'(lap_hold), 32'(m_mode == M_LAP));
        check("tick", 32'(tick), 32'(live_mode(m_mode) && m_frac == TD - 1));
        check("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            step();
            @(negedge clk);
            compare();
        end
    endtask

    task automatic push(input int idx, input int hold);
        if (idx == 0) btn_lap = 1'b1;
        if (idx == 1) btn_start_stop = 1'b1;
        if (idx == 2) btn_clear = 1'b1;
        cyc(hold);
        btn_lap        = 1'b0;
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        cyc(6);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        btn_start_stop = 1'b0;
        btn_lap        = 1'b0;
        btn_clear      = 1'b0;
        mreset();
        cyc(3);
        rst = 1'b0;

        // start, count 40 ticks, glitch, laps
        cyc(10);
        push(1, 8);
        cyc(160);
        btn_start_stop = 1'b1;
        cyc(2);
        btn_start_stop = 1'b0;
        cyc(10);
        push(0, 5);
        cyc(40);
        push(0, 5);
        cyc(30);
        push(2, 6);
        push(1, 6);
        cyc(20);
        push(2, 6);

        // run through 9999 -> 0000, then stop and clear
        push(1, 6);
        cyc(40100);
        push(0, 6);
        cyc(20);
        push(1, 6);
        cyc(10);
        push(2, 6);

        // clear and start/stop together in STOP
        push(1, 6);
        cyc(30);
        push(1, 6);
        btn_clear      = 1'b1;
        btn_start_stop = 1'b1;
        cyc(6);
        btn_clear      = 1'b0;
        btn_start_stop = 1'b0;
        cyc(10);

        // random button activity including glitches and overlaps
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) btn_lap = ~btn_lap;
            if ($urandom_range(0, 7) == 0) btn_start_stop = ~btn_start_stop;
            if ($urandom_range(0, 11) == 0) btn_clear = ~btn_clear;
            cyc(1);
        end
        btn_lap        = 1'b0;
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        cyc(10);

        // async reset mid-run while start/stop is held through it
        push(1, 6);
        cyc(25);
        btn_start_stop = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_digits", 32'(digits), 32'h0);
        check("arst_running", 32'(running), 32'h0);
        check("arst_lap_hold", 32'(lap_hold), 32'h0);
        check("arst_tick", 32'(tick), 32'h0);
        check("arst_ovf", 32'(ovf), 32'h0);
        mreset();
        @(negedge clk);
        cyc(2);
        rst = 1'b0;
        cyc(20);
        btn_start_stop = 1'b0;
        cyc(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
